uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an oversampling baud counter.
// The start bit is confirmed at its midpoint, and every later bit is sampled
// one bit time after that, which puts each sample near the middle of its bit.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input (idle high, LSB first)
//   data       last correctly framed byte
//   valid      one-cycle pulse; data is new and stable on this cycle
//   frame_err  one-cycle pulse; the stop bit was sampled low
//   busy       high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned DIV   = CLK_FREQ / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = 16;

   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] baud_nxt;
   logic [2:0]       bit_cnt;
   logic [2:0]       bit_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic [7:0]       data_nxt;
   logic             valid_nxt;
   logic             ferr_nxt;
   logic             busy_nxt;

   logic             rx_m;
   logic             rx_s;
   logic             rx_d;

   // Two-flop synchronizer plus one delay stage for edge detection.
   // All three reset high so releasing reset never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_cnt   <= bit_nxt;
         shift     <= shift_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      data_nxt  = data;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;

      case (state)
         IDLE: begin
            // Only a real high-to-low transition starts a frame; a line
            // that is simply stuck low is ignored.
            if (rx_d && !rx_s) begin
               state_nxt = START;
               baud_nxt  = '0;
            end
         end

         START: begin
            if (baud_cnt == HALF_LAST) begin
               baud_nxt = '0;
               if (!rx_s) begin
                  state_nxt = DATA;
                  bit_nxt   = '0;
               end else begin
                  // Line went back high before mid start bit: treat as noise.
                  state_nxt = IDLE;
               end
            end else begin
               baud_nxt = baud_cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (baud_cnt == DIV_LAST) begin
               shift_nxt[bit_cnt] = rx_s;
               baud_nxt           = '0;
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  bit_nxt = bit_cnt + 3'd1;
               end
            end else begin
               baud_nxt = baud_cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (baud_cnt == DIV_LAST) begin
               state_nxt = IDLE;
               baud_nxt  = '0;
               if (rx_s) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end else begin
               baud_nxt = baud_cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            baud_nxt  = '0;
         end
      endcase

      // Registered from the next state so busy tracks the state exactly.
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. The driver serialises frames and
// queues the expected outcome of each one (byte or framing error); a monitor
// pops and checks an entry whenever the receiver pulses valid or frame_err.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 50_000_000;
   localparam int unsigned BAUD     = 115200;
   localparam int unsigned DIV      = CLK_FREQ / BAUD;
   localparam int unsigned HALF     = DIV / 2;
   localparam int          LAT      = 2 + HALF + 9 * DIV + 2;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   typedef struct {
      logic       is_err;
      logic [7:0] b;
      int         t_fall;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec;
   int         n_err;
   int         cyc;
   logic [7:0] last_good;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endfunction

   // Serialise one 8N1 frame starting at a negedge; queue its expected outcome.
   task automatic send(input logic [7:0] b, input logic stop_ok, input int gap);
      exp_t e;
      e.is_err = ~stop_ok;
      e.b      = b;
      e.t_fall = cyc;
      exp_q.push_back(e);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop_ok;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 4 * DIV; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      int   lat;
      forever begin
         @(negedge clk);
         if (!rst && (valid || frame_err)) begin
            chk("exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b with nothing expected (cycle %0d)",
                        valid, frame_err, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.is_err) begin
                  chk("ferr_kind", {31'd0, frame_err}, 32'd1);
                  chk("ferr_data_hold", {24'd0, data}, {24'd0, last_good});
               end else begin
                  chk("valid_kind", {31'd0, valid}, 32'd1);
                  chk("data", {24'd0, data}, {24'd0, e.b});
                  lat = cyc - e.t_fall;
                  chk_rng("latency", lat, LAT - 1, LAT + 1);
                  last_good = e.b;
               end
            end
            @(negedge clk);
            chk("pulse_width", {31'd0, valid | frame_err}, 32'd0);
         end
      end
   end

   // Hard bound on total run time.
   initial begin
      #(10 * 95_000);
      $display("FAIL timeout: simulation exceeded cycle budget (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int   cnt;
      logic [7:0] b;
      logic       ok;
      int   gap;

      n_vec     = 0;
      n_err     = 0;
      last_good = 8'h00;
      rst       = 1'b1;
      rx        = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Single byte, then idle.
      send(8'h55, 1'b1, DIV);
      drain("drain_55");
      chk("busy_after_55", {31'd0, busy}, 32'd0);

      // Back-to-back frames with no idle gap.
      send(8'hA3, 1'b1, 0);
      send(8'h0F, 1'b1, DIV);
      drain("drain_a3_0f");

      // Short low glitch: busy for about half a bit, then idle, no pulse.
      cnt = 0;
      rx  = 1'b0;
      repeat (100) begin
         @(negedge clk);
         cnt += int'(busy);
      end
      rx = 1'b1;
      repeat (3 * DIV) begin
         @(negedge clk);
         cnt += int'(busy);
      end
      chk_rng("glitch_busy_cycles", cnt, HALF - 1, HALF + 2);
      chk("glitch_busy_end", {31'd0, busy}, 32'd0);

      // Stop bit forced low.
      send(8'h3C, 1'b0, 2 * DIV);
      drain("drain_3c");

      // Line held low for 20 bit times: one framing error, then recovery.
      begin
         exp_t e;
         e.is_err = 1'b1;
         e.b      = 8'h00;
         e.t_fall = cyc;
         exp_q.push_back(e);
      end
      rx = 1'b0;
      repeat (20 * DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      chk("stuck_low_consumed", 32'(exp_q.size()), 32'd0);
      send(8'h81, 1'b1, DIV);
      drain("drain_81");

      // Reset during bit 4 of a frame aborts it silently.
      b  = 8'h5A;
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = b[4];
      repeat (DIV / 2) @(negedge clk);
      chk("busy_mid_frame", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_data", {24'd0, data}, 32'd0);
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      last_good = 8'h00;
      rst = 1'b0;
      rx  = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      chk("idle_after_rst", {31'd0, busy}, 32'd0);
      send(8'hE7, 1'b1, DIV);
      drain("drain_e7");

      // Random frames, occasionally with a bad stop bit.
      for (int k = 0; k < 4; k++) begin
         b   = 8'($urandom_range(0, 255));
         ok  = ($urandom_range(0, 3) != 0);
         gap = ok ? int'($urandom_range(0, DIV)) : int'($urandom_range(4, DIV));
         send(b, ok, gap);
      end
      repeat (DIV) @(negedge clk);
      drain("drain_random");
      chk("busy_final", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
